iccm_arbiter: RTL and testbench

Two-requester arbiter in front of the instruction memory wrapper `instr_mem_top`, sharing its single port between the core instruction-fetch port (read-only) and the program loader/debug port (read/write). It selects one request per cycle with round-robin fairness. It supports a loader lock for uninterrupted burst writes, bounded by a starvation limit. It generates the per-requester response strobe and routes read data back to the port that issued the access.

---
 rtl/iccm_pkg.sv | 21 ++
 rtl/iccm_arbiter.sv | 178 +++++++++++++++++
 tb/tb_iccm_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iccm_pkg.sv
// Shared types and default sizes for the instruction-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iccm_pkg;

    // Requester identity; also the encoding of the round-robin "last" pointer.
    typedef enum logic {
        CORE = 1'b0,
        LD   = 1'b1
    } port_e;

    // Arbiter ownership state.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    localparam int ICCM_AW = 12;
    localparam int ICCM_DW = 32;

endpackage

// File: rtl/iccm_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between core fetch and loader/debug.
// Latency: grant is combinational in the request cycle; response strobe exactly 1 cycle later.
// Backpressure: requesters hold req/fields until gnt; a loader lock holds off the core up to LOCK_MAX cycles.
//
// Ports:
//   clock, reset          - single clock, asynchronous active-low reset
//   core_req/addr         - core fetch request (read-only); core_gnt accepts it
//   core_rvalid/rdata     - core read response, one cycle after core_gnt
//   ld_req/addr/wdata/we  - loader request; ld_we==0 is a read, else byte write mask
//   ld_lock               - keep ownership after this loader grant
//   ld_gnt                - loader request accepted
//   ld_rvalid/rdata       - loader completion (read data or write done), one cycle after ld_gnt
//   mem_req/addr/wdata/we - drive to the memory wrapper
//   mem_rdata             - memory read data, valid one cycle after mem_req
module iccm_arbiter
    import iccm_pkg::*;
#(
    parameter int AW       = ICCM_AW,
    parameter int DW       = ICCM_DW,
    parameter int LOCK_MAX = 16
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic [3:0]    ld_we,
    input  logic          ld_lock,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,

    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW      = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    arb_state_e    state_q, state_d;
    port_e         last_q, last_d;
    port_e         owner_q, owner_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    logic          core_win;
    logic          ld_win;

    // ------------------------------------------------------------------
    // Arbitration and next-state
    // ------------------------------------------------------------------
    always_comb begin
        core_win   = 1'b0;
        ld_win     = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;

        case (state_q)
            UNLOCKED: begin
                if (core_req && ld_req) begin
                    // Tie: the port that did not win last time goes now.
                    if (last_q == CORE) begin
                        ld_win = 1'b1;
                    end else begin
                        core_win = 1'b1;
                    end
                end else if (core_req) begin
                    core_win = 1'b1;
                end else if (ld_req) begin
                    ld_win = 1'b1;
                end

                // Only a loader grant can take the lock; ld_lock beside a
                // core grant is ignored.
                if (ld_win && ld_lock) begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end
            end

            LOCKED: begin
                if (core_req && (lock_cnt_q == CNT_MAX)) begin
                    // Starvation limit reached: force one core access and
                    // drop the lock so round-robin resumes.
                    core_win   = 1'b1;
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else begin
                    ld_win = ld_req;
                    if (core_req && (lock_cnt_q != CNT_MAX)) begin
                        lock_cnt_d = lock_cnt_q + CW'(1);
                    end
                    // Exit covers both "granted with lock released" and
                    // "idle with lock released"; in either case ld_lock==0.
                    // The exit cycle itself still belongs to the loader.
                    if (!ld_lock) begin
                        state_d = UNLOCKED;
                    end
                end
            end

            default: begin
                state_d = UNLOCKED;
            end
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (core_win) begin
            last_d = CORE;
        end else if (ld_win) begin
            last_d = LD;
        end
    end

    // Response bookkeeping: remember whether an access went out and whose
    // it was, so the next-cycle memory data is steered to the right port.
    always_comb begin
        pend_d  = core_win | ld_win;
        owner_d = owner_q;
        if (ld_win) begin
            owner_d = LD;
        end else if (core_win) begin
            owner_d = CORE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= UNLOCKED;
            last_q     <= LD;
            owner_q    <= CORE;
            pend_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            pend_q     <= pend_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Grants and memory drive
    // ------------------------------------------------------------------
    assign core_gnt  = core_win;
    assign ld_gnt    = ld_win;

    assign mem_req   = core_win | ld_win;
    assign mem_addr  = ld_win ? ld_addr  : core_addr;
    // Core fetches are always reads; nothing is written when idle.
    assign mem_wdata = ld_win ? ld_wdata : '0;
    assign mem_we    = ld_win ? ld_we    : 4'h0;

    // ------------------------------------------------------------------
    // Responses
    // ------------------------------------------------------------------
    assign core_rvalid = pend_q && (owner_q == CORE);
    assign ld_rvalid   = pend_q && (owner_q == LD);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign ld_rdata    = ld_rvalid   ? mem_rdata : '0;

endmodule

// File: tb/tb_iccm_arbiter.sv
// Directed bench for iccm_arbiter with a scoreboard on the response side.
// Latency: checks grants in the request cycle and rvalid/rdata one cycle later.
// Backpressure: stimulus holds a request until the expected grant cycle.
module tb_iccm_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          core_req = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic          core_gnt;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic [3:0]    ld_we = 4'h0;
    logic          ld_lock = 1'b0;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_we;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clock = ~clock;

    iccm_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .LOCK_MAX (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_we       (ld_we),
        .ld_lock     (ld_lock),
        .ld_gnt      (ld_gnt),
        .ld_rvalid   (ld_rvalid),
        .ld_rdata    (ld_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Memory model: unwritten words read as 0xC0DE_0000 | addr.
    // ------------------------------------------------------------------
    logic [31:0] mem_wr [int];
    logic [31:0] mem_word;

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        if (mem_wr.exists(int'(a))) begin
            return mem_wr[int'(a)];
        end
        return 32'hC0DE_0000 | {20'h0, a};
    endfunction

    always @(posedge clock) begin
        if (mem_req) begin
            mem_word = mem_rd(mem_addr);
            mem_rdata <= mem_word;
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) begin
                    mem_word[8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
            if (mem_we != 4'h0) begin
                mem_wr[int'(mem_addr)] = mem_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    exp_t core_q[$];
    exp_t ld_q[$];
    exp_t mon_c;
    exp_t mon_l;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest outstanding grant
    // of that port.
    always @(negedge clock) begin
        if (reset) begin
            if (core_rvalid) begin
                if (core_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL core_rvalid unexpected: got 1 expected 0");
                end else begin
                    mon_c = core_q.pop_front();
                    check("core_rdata", core_rdata, mon_c.dat);
                end
            end
            if (ld_rvalid) begin
                if (ld_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ld_rvalid unexpected: got 1 expected 0");
                end else begin
                    mon_l = ld_q.pop_front();
                    if (mon_l.chk) begin
                        check("ld_rdata", ld_rdata, mon_l.dat);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge+1)
    // ------------------------------------------------------------------
    task automatic step(input logic c_req, input logic [AW-1:0] c_addr,
                        input logic l_req, input logic [AW-1:0] l_addr,
                        input logic [31:0] l_wdata, input logic [3:0] l_we,
                        input logic l_lock,
                        input logic exp_cg, input logic exp_lg,
                        input logic [31:0] c_exp, input logic [31:0] l_exp,
                        input string tag);
        core_req  = c_req;
        core_addr = c_addr;
        ld_req    = l_req;
        ld_addr   = l_addr;
        ld_wdata  = l_wdata;
        ld_we     = l_we;
        ld_lock   = l_lock;
        @(negedge clock);
        check({tag, " core_gnt"}, 32'(core_gnt), 32'(exp_cg));
        check({tag, " ld_gnt"}, 32'(ld_gnt), 32'(exp_lg));
        check({tag, " mem_req"}, 32'(mem_req), 32'(exp_cg | exp_lg));
        if (exp_cg) begin
            check({tag, " mem_we(core)"}, 32'(mem_we), 32'h0);
            check({tag, " mem_addr(core)"}, 32'(mem_addr), 32'(c_addr));
            core_q.push_back('{chk: 1'b1, dat: c_exp});
        end
        if (exp_lg) begin
            check({tag, " mem_addr(ld)"}, 32'(mem_addr), 32'(l_addr));
            check({tag, " mem_we(ld)"}, 32'(mem_we), 32'(l_we));
            ld_q.push_back('{chk: (l_we == 4'h0), dat: l_exp});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0, 1'b0, 1'b0, '0, '0, tag);
    endtask

    // Reset drops any outstanding response, so the expectation queues are
    // flushed with it.
    task automatic do_reset();
        core_req = 1'b0;
        ld_req   = 1'b0;
        ld_lock  = 1'b0;
        ld_we    = 4'h0;
        reset    = 1'b0;
        core_q.delete();
        ld_q.delete();
        @(negedge clock);
        check("reset core_rvalid", 32'(core_rvalid), 32'h0);
        check("reset ld_rvalid", 32'(ld_rvalid), 32'h0);
        check("reset core_gnt", 32'(core_gnt), 32'h0);
        check("reset ld_gnt", 32'(ld_gnt), 32'h0);
        check("reset mem_req", 32'(mem_req), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        @(posedge clock);
        #1;
        do_reset();

        // Core alone, back-to-back fetches.
        step(1, 12'h010, 0, '0, '0, 4'h0, 0, 1, 0, 32'hC0DE_0010, '0, "core0");
        step(1, 12'h011, 0, '0, '0, 4'h0, 0, 1, 0, 32'hC0DE_0011, '0, "core1");
        step(1, 12'h012, 0, '0, '0, 4'h0, 0, 1, 0, 32'hC0DE_0012, '0, "core2");
        idle("core_drain");

        // Simultaneous after reset: core first, then alternate.
        do_reset();
        step(1, 12'h020, 1, 12'h030, '0, 4'h0, 0, 1, 0, 32'hC0DE_0020, '0, "tie0");
        step(1, 12'h020, 1, 12'h030, '0, 4'h0, 0, 0, 1, '0, 32'hC0DE_0030, "tie1");
        step(1, 12'h020, 1, 12'h030, '0, 4'h0, 0, 1, 0, 32'hC0DE_0020, '0, "tie2");
        step(1, 12'h020, 1, 12'h030, '0, 4'h0, 0, 0, 1, '0, 32'hC0DE_0030, "tie3");
        idle("tie_drain");

        // Loader write then read-back.
        step(0, '0, 1, 12'h040, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, '0, '0, "ldwr");
        step(0, '0, 1, 12'h040, '0, 4'h0, 0, 0, 1, '0, 32'hDEAD_BEEF, "ldrd");
        idle("ld_drain");

        // Locked burst, starvation limit 4.
        step(0, 12'h050, 1, 12'h100, 32'h0000_1000, 4'hF, 1, 0, 1, '0, '0, "lockA");
        step(1, 12'h050, 1, 12'h101, 32'h0000_1001, 4'hF, 1, 0, 1, '0, '0, "lockB");
        step(1, 12'h050, 1, 12'h102, 32'h0000_1002, 4'hF, 1, 0, 1, '0, '0, "lockC");
        step(1, 12'h050, 1, 12'h103, 32'h0000_1003, 4'hF, 1, 0, 1, '0, '0, "lockD");
        step(1, 12'h050, 1, 12'h104, 32'h0000_1004, 4'hF, 1, 0, 1, '0, '0, "lockE");
        step(1, 12'h050, 1, 12'h105, 32'h0000_1005, 4'hF, 1, 1, 0, 32'hC0DE_0050, '0, "forced");
        step(0, 12'h050, 1, 12'h105, 32'h0000_1005, 4'hF, 1, 0, 1, '0, '0, "lockG");
        step(1, 12'h050, 1, 12'h106, 32'h0000_1006, 4'hF, 1, 0, 1, '0, '0, "lockH");
        step(1, 12'h050, 1, 12'h107, 32'h0000_1007, 4'hF, 0, 0, 1, '0, '0, "exitI");
        step(1, 12'h050, 0, '0, '0, 4'h0, 0, 1, 0, 32'hC0DE_0050, '0, "afterJ");
        idle("lock_drain");

        // Lock release with no loader request.
        step(0, '0, 1, 12'h104, '0, 4'h0, 1, 0, 1, '0, 32'h0000_1004, "rel_lock");
        step(1, 12'h103, 0, '0, '0, 4'h0, 1, 0, 0, '0, '0, "rel_hold");
        step(0, '0, 0, '0, '0, 4'h0, 0, 0, 0, '0, '0, "rel_drop");
        step(1, 12'h103, 0, '0, '0, 4'h0, 0, 1, 0, 32'h0000_1003, '0, "rel_core");
        idle("rel_drain");

        // ld_lock beside a core grant must not lock.
        do_reset();
        step(1, 12'h010, 1, 12'h030, '0, 4'h0, 1, 1, 0, 32'hC0DE_0010, '0, "nolock0");
        step(1, 12'h011, 0, '0, '0, 4'h0, 0, 1, 0, 32'hC0DE_0011, '0, "nolock1");
        idle("nolock_drain");

        // Reset the cycle after a loader grant: its response is dropped.
        step(0, '0, 1, 12'h030, '0, 4'h0, 0, 0, 1, '0, 32'hC0DE_0030, "rst_ld");
        do_reset();
        step(1, 12'h012, 1, 12'h031, '0, 4'h0, 0, 1, 0, 32'hC0DE_0012, '0, "rst_tie0");
        step(1, 12'h012, 1, 12'h031, '0, 4'h0, 0, 0, 1, '0, 32'hC0DE_0031, "rst_tie1");
        idle("rst_drain");
        idle("final");

        check("core_q drained", 32'(core_q.size()), 32'h0);
        check("ld_q drained", 32'(ld_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
